// File: rtl/seg7_pkg.sv
// Shared segment encodings and frame-snapshot type for the seven-segment scan driver.
// Segment patterns are active-low, bit order g..a (bit 6 = g, bit 0 = a).
package seg7_pkg;

   localparam int unsigned N_DIGITS = 4;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

   typedef struct packed {
      logic [4*N_DIGITS-1:0] digits;
      logic [N_DIGITS-1:0]   dp_en;
      logic                  blank_lz;
   } snap_t;

   // Bit i set means digit i is a leading zero to suppress; digit 0 is never blanked.
   function automatic logic [N_DIGITS-1:0] lz_mask(input logic [4*N_DIGITS-1:0] d,
                                                   input logic en);
      logic [N_DIGITS-1:0] m;
      m    = '0;
      m[3] = en && (d[15:12] == 4'd0);
      m[2] = m[3] && (d[11:8] == 4'd0);
      m[1] = m[2] && (d[7:4] == 4'd0);
      return m;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder with blanking.
// Non-BCD codes show a dash so bad upstream data is visible rather than silent.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] value_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      if (blank_i) begin
         seg_o = SEG_OFF;
      end else begin
         case (value_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed common-anode display driver; each digit lit REFRESH_DIV cycles.
// Inputs are snapshotted once per frame so a digit never changes mid-frame.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
)
(
   input  logic                  clk,
   input  logic                  clr,
   input  logic [4*N_DIGITS-1:0] digits,
   input  logic [N_DIGITS-1:0]   dp_en,
   input  logic                  blank_lz,
   output logic [N_DIGITS-1:0]   an,
   output logic [6:0]            seg,
   output logic                  dp
);

   localparam int unsigned   CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [1:0]          idx_q, idx_d;
   snap_t               snap_q, snap_d;
   logic [N_DIGITS-1:0] an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;

   logic                wrap;
   logic [3:0]          cur_val;
   logic                cur_blank;
   logic [N_DIGITS-1:0] blank_mask;

   always_comb begin
      wrap       = (cnt_q == CNT_LAST);
      cnt_d      = wrap ? '0 : cnt_q + CW'(1);
      idx_d      = wrap ? idx_q + 2'd1 : idx_q;
      snap_d     = snap_q;
      if (wrap && (idx_q == 2'd3)) begin
         snap_d = {digits, dp_en, blank_lz};
      end
      blank_mask = lz_mask(snap_q.digits, snap_q.blank_lz);
      cur_val    = snap_q.digits[{idx_q, 2'b00} +: 4];
      cur_blank  = blank_mask[idx_q];
      an_d       = ~(N_DIGITS'(1) << idx_q);
      dp_d       = ~snap_q.dp_en[idx_q];
   end

   bcd_to_seg7 u_dec (
      .value_i (cur_val),
      .blank_i (cur_blank),
      .seg_o   (seg_d)
   );

   always_ff @(posedge clk) begin
      if (!clr) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         snap_q <= '0;
         an_q   <= '1;
         seg_q  <= SEG_OFF;
         dp_q   <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         snap_q <= snap_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
         dp_q   <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with REFRESH_DIV = 4 (16-cycle frame).
module tb_seg7_scan_driver;

   logic        clk;
   logic        clr;
   logic [15:0] digits;
   logic [3:0]  dp_en;
   logic        blank_lz;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int checks;
   int errors;
   int edge_n;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;
   localparam logic [6:0] SB = 7'b1111111;

   seg7_scan_driver #(.REFRESH_DIV(4)) dut (
      .clk      (clk),
      .clr      (clr),
      .digits   (digits),
      .dp_en    (dp_en),
      .blank_lz (blank_lz),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         edge_n++;
      end
   endtask

   // Advance to the next snapshot edge (always at least one edge).
   task automatic to_frame();
      step(1);
      while ((edge_n % 16) != 0) step(1);
   endtask

   task automatic test_reset();
      clr = 1'b0; digits = '0; dp_en = '0; blank_lz = 1'b0;
      step(2);
      checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b exp=%b", an, 4'b1111); end
      checks++; if (seg !== SB) begin errors++; $display("FAIL reset_seg got=%b exp=%b", seg, SB); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=%b", dp, 1'b1); end
      edge_n = 0;
   endtask

   task automatic test_scan_zero();
      logic [3:0] ea;
      clr = 1'b1;
      for (int e = 1; e <= 32; e++) begin
         step(1);
         if (((e - 1) % 4) == 0) begin
            ea = ~(4'b0001 << (((e - 1) / 4) % 4));
            checks++; if (an !== ea) begin errors++; $display("FAIL scan_an edge=%0d got=%b exp=%b", e, an, ea); end
            checks++; if (seg !== S0) begin errors++; $display("FAIL scan_seg edge=%0d got=%b exp=%b", e, seg, S0); end
         end
      end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL scan_dp got=%b exp=%b", dp, 1'b1); end
   endtask

   // Load inputs, wait for capture, then check every digit of the following frame.
   task automatic run_frame(input string name, input logic [15:0] d, input logic [3:0] dpe,
                            input logic blz, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
      logic [6:0] es [4];
      logic [3:0] ea;
      logic       ed;
      es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
      digits = d; dp_en = dpe; blank_lz = blz;
      to_frame();
      for (int k = 0; k < 4; k++) begin
         step(1);
         ea = ~(4'b0001 << k);
         ed = ~dpe[k];
         checks++; if (an !== ea) begin errors++; $display("FAIL %s_an%0d got=%b exp=%b", name, k, an, ea); end
         checks++; if (seg !== es[k]) begin errors++; $display("FAIL %s_seg%0d got=%b exp=%b", name, k, seg, es[k]); end
         checks++; if (dp !== ed) begin errors++; $display("FAIL %s_dp%0d got=%b exp=%b", name, k, dp, ed); end
         step(3);
      end
   endtask

   task automatic test_digits_1234();
      run_frame("d1234", 16'h1234, 4'b0100, 1'b0, S4, S3, S2, S1);
   endtask

   task automatic test_blank_0050();
      run_frame("lz0050", 16'h0050, 4'b1000, 1'b1, S0, S5, SB, SB);
   endtask

   task automatic test_blank_0000();
      run_frame("lz0000", 16'h0000, 4'b0000, 1'b1, S0, SB, SB, SB);
   endtask

   task automatic test_non_bcd();
      run_frame("dash", 16'h00C9, 4'b0000, 1'b0, S9, SD, S0, S0);
   endtask

   task automatic test_no_tearing();
      logic [6:0] es [5];
      logic [3:0] ea;
      es[0] = S1; es[1] = S1; es[2] = S1; es[3] = S2; es[4] = S2;
      digits = 16'h1111; dp_en = '0; blank_lz = 1'b0;
      to_frame();
      step(1);
      checks++; if (seg !== S1) begin errors++; $display("FAIL tear_d0 got=%b exp=%b", seg, S1); end
      step(4);
      digits = 16'h2222;
      for (int j = 0; j < 5; j++) begin
         ea = ~(4'b0001 << ((j + 1) % 4));
         checks++; if (an !== ea) begin errors++; $display("FAIL tear_an%0d got=%b exp=%b", j, an, ea); end
         checks++; if (seg !== es[j]) begin errors++; $display("FAIL tear_seg%0d got=%b exp=%b", j, seg, es[j]); end
         if (j < 4) step(4);
      end
   endtask

   task automatic test_clr_pulse();
      digits = 16'h1234; dp_en = 4'b0001; blank_lz = 1'b0;
      to_frame();
      step(1);
      checks++; if (dp !== 1'b0) begin errors++; $display("FAIL clr_pre_dp got=%b exp=%b", dp, 1'b0); end
      step(5);
      clr = 1'b0;
      step(1);
      checks++; if (an !== 4'b1111) begin errors++; $display("FAIL clr_an got=%b exp=%b", an, 4'b1111); end
      checks++; if (seg !== SB) begin errors++; $display("FAIL clr_seg got=%b exp=%b", seg, SB); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL clr_dp got=%b exp=%b", dp, 1'b1); end
      clr = 1'b1;
      edge_n = 0;
      step(1);
      checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rel_an got=%b exp=%b", an, 4'b1110); end
      checks++; if (seg !== S0) begin errors++; $display("FAIL rel_seg got=%b exp=%b", seg, S0); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rel_dp got=%b exp=%b", dp, 1'b1); end
      step(4);
      checks++; if (an !== 4'b1101) begin errors++; $display("FAIL rel_an1 got=%b exp=%b", an, 4'b1101); end
      checks++; if (seg !== S0) begin errors++; $display("FAIL rel_seg1 got=%b exp=%b", seg, S0); end
      step(12);
      checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rel_an_next got=%b exp=%b", an, 4'b1110); end
      checks++; if (seg !== S4) begin errors++; $display("FAIL rel_seg_next got=%b exp=%b", seg, S4); end
      checks++; if (dp !== 1'b0) begin errors++; $display("FAIL rel_dp_next got=%b exp=%b", dp, 1'b0); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      edge_n = 0;
      test_reset();
      test_scan_zero();
      test_digits_1234();
      test_blank_0050();
      test_blank_0000();
      test_non_bcd();
      test_no_tearing();
      test_clr_pulse();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
